// File: rtl/k423_mem_arbiter.sv
// Shares one memory port between fetch (IF) and LSU. Zero-latency request/response paths.
// Backpressure: a stalled request locks the grant; a full ID FIFO blocks both requesters.
module k423_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OSTD_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_flush_i,
  input  logic              if_req_vld_i,
  input  logic [ADDR_W-1:0] if_req_addr_i,
  output logic              if_req_rdy_o,
  output logic              if_rsp_vld_o,
  output logic [DATA_W-1:0] if_rsp_rdata_o,
  input  logic              ls_req_vld_i,
  input  logic              ls_req_wen_i,
  input  logic [ADDR_W-1:0] ls_req_addr_i,
  input  logic [DATA_W-1:0] ls_req_wdata_i,
  output logic              ls_req_rdy_o,
  output logic              ls_rsp_vld_o,
  output logic [DATA_W-1:0] ls_rsp_rdata_o,
  output logic              mem_req_vld_o,
  output logic              mem_req_wen_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [DATA_W-1:0] mem_req_wdata_o,
  input  logic              mem_req_rdy_i,
  input  logic              mem_rsp_vld_i,
  input  logic [DATA_W-1:0] mem_rsp_rdata_i,
  output logic              err_o
);

  localparam int PTR_W = $clog2(OSTD_DEPTH);
  localparam int CNT_W = $clog2(OSTD_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             owner_q [OSTD_DEPTH];
  logic             kill_q  [OSTD_DEPTH];
  logic [STV_W-1:0] starve_q, starve_d;
  logic             lock_q, lock_d;
  logic             lock_own_q, lock_own_d;
  logic             err_q, err_d;

  logic full, empty, starved;
  logic grant_if, grant_ls;
  logic fire, if_fire, pop;
  logic head_own, head_kill;

  assign full    = (cnt_q == CNT_W'(OSTD_DEPTH));
  assign empty   = (cnt_q == '0);
  assign starved = (starve_q == STV_W'(STARVE_MAX));

  // Locked owner keeps the port while still valid; otherwise LSU priority with IF starvation override
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (!full && !rst_i) begin
      if (lock_q && lock_own_q == OWN_LS && ls_req_vld_i) begin
        grant_ls = 1'b1;
      end else if (lock_q && lock_own_q == OWN_IF && if_req_vld_i) begin
        grant_if = 1'b1;
      end else if (ls_req_vld_i && if_req_vld_i) begin
        grant_if = starved;
        grant_ls = ~starved;
      end else begin
        grant_ls = ls_req_vld_i;
        grant_if = if_req_vld_i;
      end
    end
  end

  assign mem_req_vld_o   = grant_if | grant_ls;
  assign mem_req_wen_o   = grant_ls & ls_req_wen_i;
  assign mem_req_addr_o  = grant_ls ? ls_req_addr_i : if_req_addr_i;
  assign mem_req_wdata_o = grant_ls ? ls_req_wdata_i : '0;

  assign fire         = mem_req_vld_o & mem_req_rdy_i;
  assign if_fire      = fire & grant_if;
  assign if_req_rdy_o = grant_if & mem_req_rdy_i & ~full;
  assign ls_req_rdy_o = grant_ls & mem_req_rdy_i & ~full;

  assign head_own       = owner_q[rd_ptr_q];
  assign head_kill      = kill_q[rd_ptr_q];
  assign pop            = mem_rsp_vld_i & ~empty & ~rst_i;
  assign if_rsp_vld_o   = pop & (head_own == OWN_IF) & ~head_kill;
  assign ls_rsp_vld_o   = pop & (head_own == OWN_LS) & ~head_kill;
  assign if_rsp_rdata_o = mem_rsp_rdata_i;
  assign ls_rsp_rdata_o = mem_rsp_rdata_i;
  assign err_o          = err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (fire && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!fire && pop) cnt_d = cnt_q - CNT_W'(1);

    starve_d = starve_q;
    if (if_fire)                       starve_d = '0;
    else if (if_req_vld_i && !starved) starve_d = starve_q + STV_W'(1);

    lock_d     = mem_req_vld_o & ~mem_req_rdy_i;
    lock_own_d = grant_ls;
    err_d      = err_q | (mem_rsp_vld_i & empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      starve_q   <= '0;
      lock_q     <= 1'b0;
      lock_own_q <= OWN_IF;
      err_q      <= 1'b0;
      for (int i = 0; i < OSTD_DEPTH; i++) begin
        owner_q[i] <= OWN_IF;
        kill_q[i]  <= 1'b0;
      end
    end else begin
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      err_q      <= err_d;
      if (if_flush_i) begin
        for (int i = 0; i < OSTD_DEPTH; i++) begin
          if (owner_q[i] == OWN_IF) kill_q[i] <= 1'b1;
        end
      end
      // The push lands after the flush sweep so a same-cycle IF push is also killed
      if (fire) begin
        owner_q[wr_ptr_q] <= grant_ls;
        kill_q[wr_ptr_q]  <= grant_if & if_flush_i;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

endmodule

// File: tb/tb_k423_mem_arbiter.sv
// Directed bench for k423_mem_arbiter: vector table for arbitration/starvation, hand sequences for lock, fill, flush, orphan and reset.
module tb_k423_mem_arbiter;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] IF_ADDR  = 32'h0000_0100;
  localparam logic [31:0] LS_ADDR  = 32'h0000_0200;
  localparam logic [31:0] LS_WDATA = 32'h0000_DEAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_flush, if_req_vld, if_req_rdy, if_rsp_vld;
  logic [31:0] if_req_addr, if_rsp_rdata;
  logic        ls_req_vld, ls_req_wen, ls_req_rdy, ls_rsp_vld;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_rsp_rdata;
  logic        mem_req_vld, mem_req_wen, mem_req_rdy, mem_rsp_vld, err;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  k423_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst), .if_flush_i(if_flush),
    .if_req_vld_i(if_req_vld), .if_req_addr_i(if_req_addr), .if_req_rdy_o(if_req_rdy),
    .if_rsp_vld_o(if_rsp_vld), .if_rsp_rdata_o(if_rsp_rdata),
    .ls_req_vld_i(ls_req_vld), .ls_req_wen_i(ls_req_wen), .ls_req_addr_i(ls_req_addr),
    .ls_req_wdata_i(ls_req_wdata), .ls_req_rdy_o(ls_req_rdy),
    .ls_rsp_vld_o(ls_rsp_vld), .ls_rsp_rdata_o(ls_rsp_rdata),
    .mem_req_vld_o(mem_req_vld), .mem_req_wen_o(mem_req_wen), .mem_req_addr_o(mem_req_addr),
    .mem_req_wdata_o(mem_req_wdata), .mem_req_rdy_i(mem_req_rdy),
    .mem_rsp_vld_i(mem_rsp_vld), .mem_rsp_rdata_i(mem_rsp_rdata), .err_o(err)
  );

  typedef struct {
    logic iv, lv, wen, rdy, fl, rv;
    logic [31:0] rd;
    logic mv, mw, ir, lr, irv, lrv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge, then waits for the falling edge to sample
  task automatic apply(input logic iv, input logic lv, input logic wen, input logic rdy,
                       input logic fl, input logic rv, input logic [31:0] rd);
    @(posedge clk);
    #1;
    if_req_vld  = iv;
    ls_req_vld  = lv;
    ls_req_wen  = wen;
    mem_req_rdy = rdy;
    if_flush    = fl;
    mem_rsp_vld = rv;
    mem_rsp_rdata = rd;
    @(negedge clk);
  endtask

  task automatic chk_req(input string tag, input logic mv, input logic mw,
                         input logic ir, input logic lr);
    chk({tag, ".mem_vld"}, {31'd0, mem_req_vld}, {31'd0, mv});
    chk({tag, ".mem_wen"}, {31'd0, mem_req_wen}, {31'd0, mw});
    chk({tag, ".if_rdy"},  {31'd0, if_req_rdy},  {31'd0, ir});
    chk({tag, ".ls_rdy"},  {31'd0, ls_req_rdy},  {31'd0, lr});
  endtask

  task automatic chk_rsp(input string tag, input logic irv, input logic lrv);
    chk({tag, ".if_rsp_vld"}, {31'd0, if_rsp_vld}, {31'd0, irv});
    chk({tag, ".ls_rsp_vld"}, {31'd0, ls_rsp_vld}, {31'd0, lrv});
  endtask

  initial begin
    if_flush = 0; if_req_vld = 1; ls_req_vld = 1; ls_req_wen = 1;
    mem_req_rdy = 1; mem_rsp_vld = 1; mem_rsp_rdata = 32'h55;
    if_req_addr = IF_ADDR; ls_req_addr = LS_ADDR; ls_req_wdata = LS_WDATA;

    // Outputs forced low while reset is held, even with every input active
    #12;
    chk_req("reset", N, N, N, N);
    chk_rsp("reset", N, N);
    chk("reset.err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 0;
    if_req_vld = 0; ls_req_vld = 0; mem_rsp_vld = 0;

    // Both valid every cycle: L,L,L,L,I,L,L,L,L,I then a drain; each response belongs to the previous grant
    tbl[0]  = '{Y,Y,Y,Y,N,N,32'h1000, Y,Y,N,Y,N,N};
    tbl[1]  = '{Y,Y,Y,Y,N,Y,32'h1001, Y,Y,N,Y,N,Y};
    tbl[2]  = '{Y,Y,Y,Y,N,Y,32'h1002, Y,Y,N,Y,N,Y};
    tbl[3]  = '{Y,Y,Y,Y,N,Y,32'h1003, Y,Y,N,Y,N,Y};
    tbl[4]  = '{Y,Y,Y,Y,N,Y,32'h1004, Y,N,Y,N,N,Y};
    tbl[5]  = '{Y,Y,Y,Y,N,Y,32'h1005, Y,Y,N,Y,Y,N};
    tbl[6]  = '{Y,Y,Y,Y,N,Y,32'h1006, Y,Y,N,Y,N,Y};
    tbl[7]  = '{Y,Y,Y,Y,N,Y,32'h1007, Y,Y,N,Y,N,Y};
    tbl[8]  = '{Y,Y,Y,Y,N,Y,32'h1008, Y,Y,N,Y,N,Y};
    tbl[9]  = '{Y,Y,Y,Y,N,Y,32'h1009, Y,N,Y,N,N,Y};
    tbl[10] = '{N,N,N,Y,N,Y,32'h100A, N,N,N,N,Y,N};

    for (int i = 0; i < 11; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      apply(tbl[i].iv, tbl[i].lv, tbl[i].wen, tbl[i].rdy, tbl[i].fl, tbl[i].rv, tbl[i].rd);
      chk_req(tag, tbl[i].mv, tbl[i].mw, tbl[i].ir, tbl[i].lr);
      chk_rsp(tag, tbl[i].irv, tbl[i].lrv);
      if (tbl[i].mv) begin
        chk({tag, ".addr"},  mem_req_addr,  tbl[i].lr ? LS_ADDR : IF_ADDR);
        chk({tag, ".wdata"}, mem_req_wdata, tbl[i].lr ? LS_WDATA : 32'h0);
      end
      chk({tag, ".if_rdata"}, if_rsp_rdata, tbl[i].rd);
      chk({tag, ".ls_rdata"}, ls_rsp_rdata, tbl[i].rd);
    end

    // LSU write stalled three cycles; IF arrives in cycle 1 and must not steal the port
    apply(N, Y, Y, N, N, N, 0); chk_req("lockL.c0", Y, Y, N, N);
    apply(Y, Y, Y, N, N, N, 0); chk_req("lockL.c1", Y, Y, N, N);
    chk("lockL.c1.addr", mem_req_addr, LS_ADDR);
    apply(Y, Y, Y, N, N, N, 0); chk_req("lockL.c2", Y, Y, N, N);
    chk("lockL.c2.wdata", mem_req_wdata, LS_WDATA);
    apply(Y, Y, Y, Y, N, N, 0); chk_req("lockL.c3", Y, Y, N, Y);
    apply(Y, N, N, Y, N, N, 0); chk_req("lockL.c4", Y, N, Y, N);
    apply(N, N, N, Y, N, Y, 32'h21); chk_rsp("lockL.r0", N, Y);
    apply(N, N, N, Y, N, Y, 32'h22); chk_rsp("lockL.r1", Y, N);

    // IF stalled first keeps the grant even though the higher-priority LSU turns valid
    apply(Y, N, N, N, N, N, 0); chk_req("lockI.c0", Y, N, N, N);
    apply(Y, Y, Y, N, N, N, 0); chk_req("lockI.c1", Y, N, N, N);
    chk("lockI.c1.addr", mem_req_addr, IF_ADDR);
    apply(Y, Y, Y, Y, N, N, 0); chk_req("lockI.c2", Y, N, Y, N);
    apply(Y, Y, Y, Y, N, N, 0); chk_req("lockI.c3", Y, Y, N, Y);
    apply(N, N, N, Y, N, Y, 32'h31); chk_rsp("lockI.r0", Y, N);
    apply(N, N, N, Y, N, Y, 32'h32); chk_rsp("lockI.r1", N, Y);
    chk("err.before", {31'd0, err}, 32'd0);

    // Fill four IF reads; a same-cycle pop does not lift full; drain 0xA..0xD in order
    for (int i = 0; i < 4; i++) begin
      apply(Y, N, N, Y, N, N, 0);
      chk_req($sformatf("fill%0d", i), Y, N, Y, N);
    end
    apply(Y, N, N, Y, N, Y, 32'hA); chk_req("full", N, N, N, N);
    chk_rsp("full", Y, N);
    chk("full.rdata", if_rsp_rdata, 32'hA);
    for (int i = 1; i < 4; i++) begin
      apply(N, N, N, Y, N, Y, 32'hA + i);
      chk_rsp($sformatf("drain%0d", i), Y, N);
      chk($sformatf("drain%0d.rdata", i), if_rsp_rdata, 32'hA + i);
    end

    // Flush with I,L,I outstanding, then a fresh IF; only the LSU and the new IF respond
    apply(Y, N, N, Y, N, N, 0); chk_req("fl.i0", Y, N, Y, N);
    apply(N, Y, N, Y, N, N, 0); chk_req("fl.l1", Y, N, N, Y);
    apply(Y, N, N, Y, N, N, 0); chk_req("fl.i2", Y, N, Y, N);
    apply(N, N, N, Y, Y, N, 0);
    apply(Y, N, N, Y, N, N, 0); chk_req("fl.i3", Y, N, Y, N);
    apply(N, N, N, Y, N, Y, 32'h11); chk_rsp("fl.r0", N, N);
    apply(N, N, N, Y, N, Y, 32'h12); chk_rsp("fl.r1", N, Y);
    apply(N, N, N, Y, N, Y, 32'h13); chk_rsp("fl.r2", N, N);
    apply(N, N, N, Y, N, Y, 32'h14); chk_rsp("fl.r3", Y, N);
    chk("fl.r3.rdata", if_rsp_rdata, 32'h14);
    // IF push in the flush cycle is still accepted but its response is dropped
    apply(Y, N, N, Y, Y, N, 0); chk_req("fl.same", Y, N, Y, N);
    apply(N, N, N, Y, N, Y, 32'h15); chk_rsp("fl.same.r", N, N);

    // Orphan response with empty FIFO: silent, err sticky from the next cycle
    apply(N, N, N, Y, N, Y, 32'h77); chk_rsp("orphan", N, N);
    chk("orphan.err0", {31'd0, err}, 32'd0);
    apply(N, N, N, Y, N, N, 0); chk("orphan.err1", {31'd0, err}, 32'd1);
    apply(N, N, N, Y, N, N, 0); chk("orphan.err2", {31'd0, err}, 32'd1);

    // Asynchronous reset with two IF reads outstanding
    apply(Y, N, N, Y, N, N, 0);
    apply(Y, N, N, Y, N, N, 0);
    @(posedge clk);
    #1;
    mem_rsp_vld = 1; mem_rsp_rdata = 32'h88;
    #1;
    chk("prerst.if_rdy", {31'd0, if_req_rdy}, 32'd1);
    chk("prerst.if_rsp", {31'd0, if_rsp_vld}, 32'd1);
    rst = 1;
    #1;
    chk_req("midrst", N, N, N, N);
    chk_rsp("midrst", N, N);
    chk("midrst.err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 0;
    if_req_vld = 0; mem_rsp_vld = 0;
    apply(N, N, N, Y, N, Y, 32'h99); chk_rsp("postrst.rsp", N, N);
    apply(N, N, N, Y, N, N, 0); chk("postrst.err", {31'd0, err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/k423_mem_arbiter.md
# k423_mem_arbiter

Two-port to one-port memory arbiter between the IF fetch unit and the LSU. The core shares a single unified memory port. The block chooses which requester owns that port each cycle and tracks in-flight requests in an in-order ID FIFO. Responses are routed back to their owner, and stale fetch responses are dropped after a branch flush.

## Interface
Parameters:
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, write/read data width (fetch width equals `DATA_W`)
- `OSTD_DEPTH`, 4, maximum outstanding requests (power of two, ≥2)
- `STARVE_MAX`, 4, consecutive IF losses before IF is forced to win

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `if_flush_i`  in  1  branch flush; kills IF responses still in flight
- `if_req_vld_i / if_req_addr_i`  in  1 / `ADDR_W`  fetch request (read only)
- `if_req_rdy_o`  out  1  fetch request accepted
- `if_rsp_vld_o / if_rsp_rdata_o`  out  1 / `DATA_W`  fetch response
- `ls_req_vld_i / ls_req_wen_i`  in  1 / 1  LSU request valid, write enable
- `ls_req_addr_i / ls_req_wdata_i`  in  `ADDR_W` / `DATA_W`  LSU address, write data
- `ls_req_rdy_o`  out  1  LSU request accepted
- `ls_rsp_vld_o / ls_rsp_rdata_o`  out  1 / `DATA_W`  LSU response (writes return an ack)
- `mem_req_vld_o / mem_req_wen_o / mem_req_addr_o / mem_req_wdata_o`  out  1 / 1 / `ADDR_W` / `DATA_W`  shared memory request
- `mem_req_rdy_i`  in  1  memory accepts request
- `mem_rsp_vld_i / mem_rsp_rdata_i`  in  1 / `DATA_W`  memory response, in order, one response per accepted request
- `err_o`  out  1  sticky: a response arrived while the FIFO was empty

## Operation
- **Fire.** `fire = mem_req_vld_o & mem_req_rdy_i`. Requester ready: `x_req_rdy_o = grant_x & mem_req_rdy_i & ~full`.
- **Arbitration.**
  - Only one valid: that requester is granted.
  - Both valid: the LSU wins, unless `starve_cnt == STARVE_MAX`, in which case the IF wins.
  - If `full`, no grant is made and `mem_req_vld_o = 0`.
- **Lock.** When a request is presented but not accepted (`mem_req_vld_o & ~mem_req_rdy_i`), the owner is registered. That owner keeps the grant every cycle until it fires, even if the other requester becomes valid. The lock clears on fire. If the locked owner drops its valid, the lock also clears; this is a requester protocol violation and is tolerated.
- **Request mux.** The granted requester drives `mem_req_*`. For IF: `wen = 0`, `wdata = 0`.
- **ID FIFO.** `OSTD_DEPTH` entries, each holding `{owner, kill}`.
  - On fire: push `{owner, 0}`.
  - On `mem_rsp_vld_i`: pop the head.
  - Head `owner=IF, kill=0`: `if_rsp_vld_o = 1`. Head `owner=LSU`: `ls_rsp_vld_o = 1`. Head `kill=1`: the response is consumed silently.
  - `rdata` is passed through to both response ports unconditionally.
- **Flush.** `if_flush_i` sets `kill` on every valid IF entry in the FIFO. An IF push in the same cycle as a flush is also killed. During a flush, `if_req_rdy_o` is still permitted, because the fetch unit has already issued the redirected PC.
- **Starvation counter.**
  - Increments, saturating at `STARVE_MAX`, in each cycle where `if_req_vld_i & ~if_fire`.
  - Clears on IF fire.
  - Holds when IF is not valid.
- **Response with empty FIFO.** No pop, no response valid asserted, `err_o` set until reset.
- **Push and pop in the same cycle.** Occupancy is unchanged. `full` is evaluated on registered occupancy, so a pop does not relieve `full` in the same cycle.

## Timing
- **Request path.** Combinational: requester valid → `mem_req_vld_o`, and `mem_req_rdy_i` → `x_req_rdy_o`. Zero added latency.
- **Response path.** Combinational: `mem_rsp_vld_i` → `x_rsp_vld_o` in the same cycle.
- **Memory requirements.** The memory responds at least one cycle after acceptance, in strict order.
- **Occupancy.** Registered, range 0..`OSTD_DEPTH`, with wrapping read/write pointers of `$clog2(OSTD_DEPTH)` bits. `full = (cnt == OSTD_DEPTH)`.
- **Reset values.**
  - FIFO empty, pointers 0, `starve_cnt = 0`, lock clear, `err_o = 0`.
  - While `rst_i` is high, `mem_req_vld_o`, both `x_req_rdy_o` and both `x_rsp_vld_o` are forced to 0.
  - Reset asserted mid-transaction discards all outstanding IDs. Any responses arriving after reset therefore set `err_o`.

## Test plan
- **Both valid continuously, `mem_req_rdy_i=1`, `STARVE_MAX=4`.** Grant order is L,L,L,L,I,L,L,L,L,I…; `starve_cnt` follows 0→4, then resets on the IF grant.
- **LSU write stalled.** LSU write presented with `mem_req_rdy_i=0` for 3 cycles, and IF becomes valid in cycle 1. `mem_req_*` holds the LSU write (`wen=1`) for all 3 cycles and the IF is not granted. On cycle 4 with `rdy=1`, the LSU fires and the lock clears.
- **FIFO fill and drain.** Issue 4 IF reads with no responses: the 5th request sees `if_req_rdy_o=0` and `mem_req_vld_o=0`. Four in-order responses 0xA..0xD then appear on `if_rsp_rdata_o` with `if_rsp_vld_o=1`, and the FIFO returns to empty.
- **Flush.** Outstanding sequence I,L,I; pulse `if_flush_i`, then issue one new IF fire. The response sequence yields only `ls_rsp_vld_o` (2nd response) and `if_rsp_vld_o` (4th response); the 1st and 3rd responses are silent.
- **Orphan response.** Assert `mem_rsp_vld_i` with the FIFO empty: `err_o` rises the next cycle and stays high. No response valid is asserted.
- **Reset mid-operation.** Assert `rst_i` asynchronously with 2 requests outstanding: all outputs drop immediately and, after release, occupancy is 0.
